stopwatch_ctrl: RTL

Command controller for the stopwatch timer datapath. It arbitrates between two command sources (host register port and front-panel button decoder) and drives the timer's `start`/`stop`/`reset` inputs as clean single-cycle pulses. It tracks run/pause state and captures lap values from the timer's `count` into a small lap FIFO. It sits directly upstream of the timer, on the same clock.

---
 rtl/stopwatch_pkg.sv | 31 +++
 rtl/stopwatch_ctrl_lap_fifo.sv | 64 ++++++
 rtl/stopwatch_ctrl.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types for the stopwatch command controller: command encoding,
// controller states and the post-accept busy phase.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        CMD_START = 2'd0,
        CMD_STOP  = 2'd1,
        CMD_CLEAR = 2'd2,
        CMD_LAP   = 2'd3
    } cmd_e;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_RUN   = 2'd2,
        ST_PAUSE = 2'd3
    } state_e;

    // PH_NONE means free to arbitrate; PULSE/GAP follow every accept.
    typedef enum logic [1:0] {
        PH_NONE  = 2'd0,
        PH_PULSE = 2'd1,
        PH_GAP   = 2'd2
    } phase_e;

    typedef enum logic {
        RR_HOST = 1'b0,
        RR_BTN  = 1'b1
    } rr_e;

endpackage

// File: rtl/stopwatch_ctrl_lap_fifo.sv
// Lap capture FIFO: power-of-two depth, synchronous flush that beats both
// push and pop, head forced to zero while empty.
module lap_fifo #(
    parameter int DATA_WIDTH = 16,
    parameter int LAP_DEPTH  = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  pop_i,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  full_o
);

    localparam int AW = $clog2(LAP_DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [DATA_WIDTH-1:0] mem_q [LAP_DEPTH];
    logic [AW:0]           wr_q, wr_d;
    logic [AW:0]           rd_q, rd_d;
    logic                  empty;
    logic                  do_push;
    logic                  do_pop;

    assign empty  = (wr_q == rd_q);
    assign full_o = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);

    // A pop frees a slot in the same cycle, so push at full is allowed with it.
    assign do_pop  = pop_i && !empty && !flush_i;
    assign do_push = push_i && (!full_o || do_pop) && !flush_i;

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (flush_i) begin
            wr_d = '0;
            rd_d = '0;
        end else begin
            if (do_push) wr_d = wr_q + PTR_ONE;
            if (do_pop)  rd_d = rd_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= push_data_i;
    end

    assign valid_o = !empty;
    assign data_o  = empty ? '0 : mem_q[rd_q[AW-1:0]];

endmodule

// File: rtl/stopwatch_ctrl.sv
// Command controller for the stopwatch timer: round-robin arbitration of
// host/panel commands, single-cycle timer pulses and lap capture.
import stopwatch_pkg::*;

module stopwatch_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int LAP_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  host_valid,
    input  logic [1:0]            host_cmd,
    output logic                  host_ready,
    input  logic                  btn_valid,
    input  logic [1:0]            btn_cmd,
    output logic                  btn_ready,
    input  logic [DATA_WIDTH-1:0] sw_count,
    output logic                  sw_start,
    output logic                  sw_stop,
    output logic                  sw_reset,
    output logic                  lap_valid,
    output logic [DATA_WIDTH-1:0] lap_data,
    input  logic                  lap_ready,
    output logic                  running,
    output logic                  paused,
    output logic                  lap_overflow,
    output logic                  err_illegal,
    output state_e                dbg_state
);

    // Handshake: a command transfers on a cycle where valid and ready are both
    // high; ready is combinational and only the granted source sees it.

    state_e state_q, state_d, pend_q, pend_d, target;
    phase_e phase_q, phase_d;
    rr_e    rr_q, rr_d;

    logic start_q, start_d;
    logic stop_q, stop_d;
    logic rst_q, rst_d;
    logic err_q, err_d;
    logic run_q, run_d;
    logic pause_q, pause_d;
    logic ovf_q, ovf_d;

    logic can_arb, grant_host, grant_btn, accept;
    cmd_e cmd;
    logic fifo_push, fifo_flush, fifo_pop, fifo_full;

    always_comb begin
        can_arb    = (state_q != ST_INIT) && (phase_q == PH_NONE);
        grant_host = can_arb && host_valid && (!btn_valid || rr_q == RR_HOST);
        grant_btn  = can_arb && btn_valid && (!host_valid || rr_q == RR_BTN);
        accept     = grant_host || grant_btn;
        cmd        = cmd_e'(grant_host ? host_cmd : btn_cmd);
        rr_d       = rr_q;
        if (grant_host)     rr_d = RR_BTN;
        else if (grant_btn) rr_d = RR_HOST;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_INIT;
            pend_q  <= ST_INIT;
            phase_q <= PH_NONE;
            rr_q    <= RR_HOST;
            start_q <= 1'b0;
            stop_q  <= 1'b0;
            rst_q   <= 1'b0;
            err_q   <= 1'b0;
            run_q   <= 1'b0;
            pause_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            phase_q <= phase_d;
            rr_q    <= rr_d;
            start_q <= start_d;
            stop_q  <= stop_d;
            rst_q   <= rst_d;
            err_q   <= err_d;
            run_q   <= run_d;
            pause_q <= pause_d;
            ovf_q   <= ovf_d;
        end
    end

    // The resulting state is latched at accept and only committed after GAP.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        pend_d  = pend_q;
        case (phase_q)
            PH_NONE: begin
                if (state_q == ST_INIT) begin
                    phase_d = PH_PULSE;
                    pend_d  = ST_IDLE;
                end else if (accept) begin
                    phase_d = PH_PULSE;
                    pend_d  = target;
                end
            end
            PH_PULSE: phase_d = PH_GAP;
            PH_GAP: begin
                phase_d = PH_NONE;
                state_d = pend_q;
            end
            default: phase_d = PH_NONE;
        endcase
    end

    always_comb begin
        start_d    = 1'b0;
        stop_d     = 1'b0;
        rst_d      = 1'b0;
        err_d      = 1'b0;
        run_d      = run_q;
        pause_d    = pause_q;
        ovf_d      = ovf_q;
        fifo_push  = 1'b0;
        fifo_flush = 1'b0;
        target     = state_q;
        if (state_q == ST_INIT && phase_q == PH_NONE) begin
            rst_d = 1'b1;
        end else if (accept) begin
            case (cmd)
                CMD_START: begin
                    if (state_q == ST_RUN) begin
                        err_d = 1'b1;
                    end else begin
                        start_d = 1'b1;
                        run_d   = 1'b1;
                        pause_d = 1'b0;
                        target  = ST_RUN;
                    end
                end
                CMD_STOP: begin
                    if (state_q == ST_RUN) begin
                        stop_d  = 1'b1;
                        run_d   = 1'b0;
                        pause_d = 1'b1;
                        target  = ST_PAUSE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                CMD_CLEAR: begin
                    rst_d      = 1'b1;
                    fifo_flush = 1'b1;
                    ovf_d      = 1'b0;
                    run_d      = 1'b0;
                    pause_d    = 1'b0;
                    target     = ST_IDLE;
                end
                default: begin
                    if (state_q == ST_IDLE) begin
                        err_d = 1'b1;
                    end else if (fifo_full && !fifo_pop) begin
                        ovf_d = 1'b1;
                    end else begin
                        fifo_push = 1'b1;
                    end
                end
            endcase
        end
    end

    assign fifo_pop = lap_valid && lap_ready;

    lap_fifo #(
        .DATA_WIDTH(DATA_WIDTH),
        .LAP_DEPTH (LAP_DEPTH)
    ) u_lap_fifo (
        .clk_i      (clk),
        .rst_i      (reset),
        .flush_i    (fifo_flush),
        .push_i     (fifo_push),
        .push_data_i(sw_count),
        .pop_i      (fifo_pop),
        .valid_o    (lap_valid),
        .data_o     (lap_data),
        .full_o     (fifo_full)
    );

    assign host_ready   = grant_host;
    assign btn_ready    = grant_btn;
    assign sw_start     = start_q;
    assign sw_stop      = stop_q;
    assign sw_reset     = rst_q;
    assign err_illegal  = err_q;
    assign running      = run_q;
    assign paused       = pause_q;
    assign lap_overflow = ovf_q;
    assign dbg_state    = state_q;

endmodule
